dlf_gear_ctrl: RTL and testbench

DLF_GEAR_CTRL -- requirements
Module: dlf_gear_ctrl

---
 rtl/dlf_gear_ctrl_if.sv | 46 ++++
 rtl/dlf_gear_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dlf_gear_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dlf_gear_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dlf_gear_ctrl_if
//  Description : Control/coefficient bundle between a sequencer (master) and
//                the loop-filter gear-shift controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dlf_gear_ctrl_if #(
    parameter int CW = 16,
    parameter int NW = 16
);
    logic          start;
    logic          stop;
    logic          dlf_tick;
    logic          lock_ind;
    logic [CW-1:0] acq_a2, acq_a3, acq_b1, acq_b2;
    logic [CW-1:0] trk_a2, trk_a3, trk_b1, trk_b2;
    logic [NW-1:0] acq_len;
    logic [7:0]    settle_len;
    logic          dlf_en;
    logic [CW-1:0] dlf_a2, dlf_a3, dlf_b1, dlf_b2;
    logic          coef_upd;
    logic [2:0]    state;
    logic          busy;
    logic          locked;
    logic [7:0]    relock_cnt;

    modport master (
        output start, stop, dlf_tick, lock_ind,
        output acq_a2, acq_a3, acq_b1, acq_b2,
        output trk_a2, trk_a3, trk_b1, trk_b2,
        output acq_len, settle_len,
        input  dlf_en, dlf_a2, dlf_a3, dlf_b1, dlf_b2,
        input  coef_upd, state, busy, locked, relock_cnt
    );

    modport slave (
        input  start, stop, dlf_tick, lock_ind,
        input  acq_a2, acq_a3, acq_b1, acq_b2,
        input  trk_a2, trk_a3, trk_b1, trk_b2,
        input  acq_len, settle_len,
        output dlf_en, dlf_a2, dlf_a3, dlf_b1, dlf_b2,
        output coef_upd, state, busy, locked, relock_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dlf_gear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dlf_gear_ctrl
//  Description : Gear-shift sequencer for a digital loop filter. Preloads the
//                acquisition coefficient set, runs acquisition for a number of
//                filter updates, then switches to the tracking set on a filter
//                update boundary. Loss of lock in tracking reverts to
//                acquisition and is counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module dlf_gear_ctrl #(
    parameter int CW = 16,
    parameter int NW = 16
) (
    input  wire logic          sys_clk,
    input  wire logic          digrf_rst,
    dlf_gear_ctrl_if.slave     bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_ACQ     = 3'd2,
        ST_SWITCH  = 3'd3,
        ST_TRACK   = 3'd4
    } state_t;

    localparam logic [NW-1:0] c_tick_one = {{(NW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic          dlf_en_q, dlf_en_d;
    logic [CW-1:0] a2_q, a3_q, b1_q, b2_q;
    logic [CW-1:0] a2_d, a3_d, b1_d, b2_d;
    logic          coef_upd_q, coef_upd_d;
    logic [7:0]    relock_q, relock_d;
    logic [NW-1:0] tick_q, tick_d;
    logic [NW-1:0] acq_len_q, acq_len_d;
    logic [7:0]    settle_q, settle_d;
    logic [7:0]    settle_cnt_q, settle_cnt_d;
    logic          w_load_acq;
    logic          w_load_trk;

    // Next-state, counters and coefficient-load selection; stop overrides
    // every transition so nothing else moves in a stop cycle.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        acq_len_d    = acq_len_q;
        settle_d     = settle_q;
        settle_cnt_d = settle_cnt_q;
        relock_d     = relock_q;
        w_load_acq   = 1'b0;
        w_load_trk   = 1'b0;

        if (bus.stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d      = ST_PRELOAD;
                        w_load_acq   = 1'b1;
                        settle_d     = bus.settle_len;
                        settle_cnt_d = 8'd0;
                    end
                end
                ST_PRELOAD: begin
                    if (settle_cnt_q == settle_q) begin
                        state_d   = ST_ACQ;
                        tick_d    = '0;
                        acq_len_d = bus.acq_len;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 8'd1;
                    end
                end
                ST_ACQ: begin
                    if (bus.dlf_tick) begin
                        tick_d = tick_q + c_tick_one;
                    end
                    // A zero length leaves after one cycle whatever the tick does.
                    if ((acq_len_q == '0) ||
                        (bus.dlf_tick && ((tick_q + c_tick_one) == acq_len_q))) begin
                        state_d = ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    if (bus.dlf_tick) begin
                        state_d    = ST_TRACK;
                        w_load_trk = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (bus.dlf_tick && !bus.lock_ind) begin
                        state_d    = ST_ACQ;
                        w_load_acq = 1'b1;
                        tick_d     = '0;
                        acq_len_d  = bus.acq_len;
                        if (relock_q != 8'hFF) begin
                            relock_d = relock_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        coef_upd_d = w_load_acq | w_load_trk;
        dlf_en_d   = (state_d == ST_ACQ) || (state_d == ST_SWITCH) || (state_d == ST_TRACK);

        a2_d = a2_q;
        a3_d = a3_q;
        b1_d = b1_q;
        b2_d = b2_q;
        if (w_load_acq) begin
            a2_d = bus.acq_a2;
            a3_d = bus.acq_a3;
            b1_d = bus.acq_b1;
            b2_d = bus.acq_b2;
        end else if (w_load_trk) begin
            a2_d = bus.trk_a2;
            a3_d = bus.trk_a3;
            b1_d = bus.trk_b1;
            b2_d = bus.trk_b2;
        end
    end

    // State, coefficient and counter registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (digrf_rst) begin
            state_q      <= ST_IDLE;
            dlf_en_q     <= 1'b0;
            a2_q         <= '0;
            a3_q         <= '0;
            b1_q         <= '0;
            b2_q         <= '0;
            coef_upd_q   <= 1'b0;
            relock_q     <= 8'd0;
            tick_q       <= '0;
            acq_len_q    <= '0;
            settle_q     <= 8'd0;
            settle_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            dlf_en_q     <= dlf_en_d;
            a2_q         <= a2_d;
            a3_q         <= a3_d;
            b1_q         <= b1_d;
            b2_q         <= b2_d;
            coef_upd_q   <= coef_upd_d;
            relock_q     <= relock_d;
            tick_q       <= tick_d;
            acq_len_q    <= acq_len_d;
            settle_q     <= settle_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign bus.dlf_en     = dlf_en_q;
    assign bus.dlf_a2     = a2_q;
    assign bus.dlf_a3     = a3_q;
    assign bus.dlf_b1     = b1_q;
    assign bus.dlf_b2     = b2_q;
    assign bus.coef_upd   = coef_upd_q;
    assign bus.state      = state_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.locked     = (state_q == ST_TRACK);
    assign bus.relock_cnt = relock_q;

endmodule
`default_nettype wire

// File: tb/tb_dlf_gear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dlf_gear_ctrl
//  Description : Directed self-checking bench for dlf_gear_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dlf_gear_ctrl;

    logic sys_clk;
    logic digrf_rst;
    int   checks;
    int   failures;

    logic signed [15:0] c_acq_a2, c_acq_a3, c_acq_b1, c_acq_b2;
    logic signed [15:0] c_trk_a2, c_trk_a3, c_trk_b1, c_trk_b2;
    logic [63:0] acq_vec, trk_vec, coef_obs;

    dlf_gear_ctrl_if #(.CW(16), .NW(16)) bus_if ();

    dlf_gear_ctrl #(.CW(16), .NW(16)) dut (
        .sys_clk   (sys_clk),
        .digrf_rst (digrf_rst),
        .bus       (bus_if)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    assign coef_obs = {bus_if.dlf_a2, bus_if.dlf_a3, bus_if.dlf_b1, bus_if.dlf_b2};

    // Advance to the next falling edge: outputs reflect the last rising edge.
    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic tick_step();
        bus_if.dlf_tick = 1'b1;
        step();
        bus_if.dlf_tick = 1'b0;
    endtask

    task automatic test_reset();
        digrf_rst = 1'b1; bus_if.start = 1'b1; bus_if.dlf_tick = 1'b1; bus_if.stop = 1'b0;
        step(); step();
        checks++; if (bus_if.state !== 3'd0) begin failures++; $display("FAIL rst_state: got %0d exp 0", bus_if.state); end
        checks++; if (bus_if.dlf_en !== 1'b0) begin failures++; $display("FAIL rst_dlf_en: got %b exp 0", bus_if.dlf_en); end
        checks++; if (coef_obs !== 64'd0) begin failures++; $display("FAIL rst_coef: got %h exp 0", coef_obs); end
        checks++; if (bus_if.coef_upd !== 1'b0) begin failures++; $display("FAIL rst_coef_upd: got %b exp 0", bus_if.coef_upd); end
        checks++; if (bus_if.busy !== 1'b0 || bus_if.locked !== 1'b0) begin failures++; $display("FAIL rst_busy_locked: got %b%b exp 00", bus_if.busy, bus_if.locked); end
        checks++; if (bus_if.relock_cnt !== 8'd0) begin failures++; $display("FAIL rst_relock: got %0d exp 0", bus_if.relock_cnt); end
        digrf_rst = 1'b0; bus_if.start = 1'b0; bus_if.dlf_tick = 1'b0;
        step();
        checks++; if (bus_if.state !== 3'd0) begin failures++; $display("FAIL idle_hold: got %0d exp 0", bus_if.state); end
    endtask

    task automatic test_preload();
        bus_if.acq_a2 = c_acq_a2; bus_if.acq_a3 = c_acq_a3; bus_if.acq_b1 = c_acq_b1; bus_if.acq_b2 = c_acq_b2;
        bus_if.trk_a2 = c_trk_a2; bus_if.trk_a3 = c_trk_a3; bus_if.trk_b1 = c_trk_b1; bus_if.trk_b2 = c_trk_b2;
        bus_if.settle_len = 8'd3; bus_if.acq_len = 16'd4; bus_if.lock_ind = 1'b1;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        checks++; if (bus_if.state !== 3'd1) begin failures++; $display("FAIL pre_state: got %0d exp 1", bus_if.state); end
        checks++; if (coef_obs !== acq_vec) begin failures++; $display("FAIL pre_coef: got %h exp %h", coef_obs, acq_vec); end
        checks++; if (bus_if.coef_upd !== 1'b1) begin failures++; $display("FAIL pre_coef_upd: got %b exp 1", bus_if.coef_upd); end
        checks++; if (bus_if.busy !== 1'b1 || bus_if.dlf_en !== 1'b0) begin failures++; $display("FAIL pre_busy_en: got %b%b exp 10", bus_if.busy, bus_if.dlf_en); end
        step();
        checks++; if (bus_if.coef_upd !== 1'b0) begin failures++; $display("FAIL pre_upd_pulse: got %b exp 0", bus_if.coef_upd); end
        step(); step();
        checks++; if (bus_if.dlf_en !== 1'b0 || bus_if.state !== 3'd1) begin failures++; $display("FAIL pre_t4: got en=%b st=%0d exp en=0 st=1", bus_if.dlf_en, bus_if.state); end
        step();
        checks++; if (bus_if.dlf_en !== 1'b1 || bus_if.state !== 3'd2) begin failures++; $display("FAIL pre_t5: got en=%b st=%0d exp en=1 st=2", bus_if.dlf_en, bus_if.state); end
    endtask

    task automatic test_acq_track();
        bus_if.acq_len = 16'd1;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        checks++; if (bus_if.state !== 3'd2 || bus_if.coef_upd !== 1'b0) begin failures++; $display("FAIL acq_start_ign: got st=%0d upd=%b exp st=2 upd=0", bus_if.state, bus_if.coef_upd); end
        for (int i = 0; i < 3; i++) begin
            repeat (7) step();
            tick_step();
            checks++; if (bus_if.state !== 3'd2) begin failures++; $display("FAIL acq_tick%0d: got %0d exp 2", i + 1, bus_if.state); end
        end
        repeat (7) step();
        tick_step();
        checks++; if (bus_if.state !== 3'd3) begin failures++; $display("FAIL acq_to_switch: got %0d exp 3", bus_if.state); end
        checks++; if (coef_obs !== acq_vec || bus_if.coef_upd !== 1'b0) begin failures++; $display("FAIL sw_coef: got %h upd=%b exp %h upd=0", coef_obs, bus_if.coef_upd, acq_vec); end
        repeat (7) step();
        checks++; if (bus_if.state !== 3'd3) begin failures++; $display("FAIL sw_wait: got %0d exp 3", bus_if.state); end
        tick_step();
        checks++; if (bus_if.state !== 3'd4 || bus_if.locked !== 1'b1 || bus_if.dlf_en !== 1'b1) begin failures++; $display("FAIL trk_state: got st=%0d lk=%b en=%b exp 4 1 1", bus_if.state, bus_if.locked, bus_if.dlf_en); end
        checks++; if (coef_obs !== trk_vec || bus_if.coef_upd !== 1'b1) begin failures++; $display("FAIL trk_coef: got %h upd=%b exp %h upd=1", coef_obs, bus_if.coef_upd, trk_vec); end
        step();
        checks++; if (bus_if.coef_upd !== 1'b0) begin failures++; $display("FAIL trk_upd_pulse: got %b exp 0", bus_if.coef_upd); end
        bus_if.acq_len = 16'd4;
    endtask

    task automatic test_relock();
        bus_if.lock_ind = 1'b0;
        repeat (5) step();
        checks++; if (bus_if.state !== 3'd4 || bus_if.relock_cnt !== 8'd0) begin failures++; $display("FAIL rl_notick: got st=%0d cnt=%0d exp 4 0", bus_if.state, bus_if.relock_cnt); end
        bus_if.lock_ind = 1'b1;
        tick_step();
        checks++; if (bus_if.state !== 3'd4) begin failures++; $display("FAIL rl_locked_tick: got %0d exp 4", bus_if.state); end
        bus_if.lock_ind = 1'b0;
        tick_step();
        bus_if.lock_ind = 1'b1;
        checks++; if (bus_if.state !== 3'd2 || bus_if.relock_cnt !== 8'd1) begin failures++; $display("FAIL rl_first: got st=%0d cnt=%0d exp 2 1", bus_if.state, bus_if.relock_cnt); end
        checks++; if (coef_obs !== acq_vec || bus_if.coef_upd !== 1'b1) begin failures++; $display("FAIL rl_coef: got %h upd=%b exp %h upd=1", coef_obs, bus_if.coef_upd, acq_vec); end
        bus_if.acq_len = 16'd0;
        repeat (3) tick_step();
        checks++; if (bus_if.state !== 3'd2) begin failures++; $display("FAIL rl_cnt_clr: got %0d exp 2", bus_if.state); end
        tick_step();
        checks++; if (bus_if.state !== 3'd3) begin failures++; $display("FAIL rl_to_switch: got %0d exp 3", bus_if.state); end
        tick_step();
        for (int i = 0; i < 299; i++) begin
            bus_if.lock_ind = 1'b0;
            tick_step();
            bus_if.lock_ind = 1'b1;
            step();
            tick_step();
            if (i == 252) begin
                checks++; if (bus_if.relock_cnt !== 8'd254) begin failures++; $display("FAIL rl_254: got %0d exp 254", bus_if.relock_cnt); end
            end
        end
        checks++; if (bus_if.relock_cnt !== 8'd255 || bus_if.state !== 3'd4) begin failures++; $display("FAIL rl_sat: got cnt=%0d st=%0d exp 255 4", bus_if.relock_cnt, bus_if.state); end
    endtask

    task automatic test_zero_len();
        digrf_rst = 1'b1;
        step();
        digrf_rst = 1'b0;
        bus_if.settle_len = 8'd0; bus_if.acq_len = 16'd0;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        checks++; if (bus_if.state !== 3'd1) begin failures++; $display("FAIL z_preload: got %0d exp 1", bus_if.state); end
        step();
        checks++; if (bus_if.state !== 3'd2 || bus_if.dlf_en !== 1'b1) begin failures++; $display("FAIL z_acq: got st=%0d en=%b exp 2 1", bus_if.state, bus_if.dlf_en); end
        tick_step();
        checks++; if (bus_if.state !== 3'd3 || bus_if.coef_upd !== 1'b0) begin failures++; $display("FAIL z_switch: got st=%0d upd=%b exp 3 0", bus_if.state, bus_if.coef_upd); end
        repeat (3) step();
        checks++; if (bus_if.state !== 3'd3) begin failures++; $display("FAIL z_switch_wait: got %0d exp 3", bus_if.state); end
    endtask

    task automatic test_stop();
        bus_if.stop = 1'b1;
        tick_step();
        bus_if.stop = 1'b0;
        checks++; if (bus_if.state !== 3'd0 || bus_if.dlf_en !== 1'b0 || bus_if.busy !== 1'b0) begin failures++; $display("FAIL stop_state: got st=%0d en=%b busy=%b exp 0 0 0", bus_if.state, bus_if.dlf_en, bus_if.busy); end
        checks++; if (coef_obs !== acq_vec || bus_if.coef_upd !== 1'b0) begin failures++; $display("FAIL stop_coef: got %h upd=%b exp %h upd=0", coef_obs, bus_if.coef_upd, acq_vec); end
        bus_if.stop = 1'b1; bus_if.start = 1'b1;
        step();
        bus_if.stop = 1'b0; bus_if.start = 1'b0;
        checks++; if (bus_if.state !== 3'd0 || bus_if.coef_upd !== 1'b0) begin failures++; $display("FAIL stop_start: got st=%0d upd=%b exp 0 0", bus_if.state, bus_if.coef_upd); end
    endtask

    task automatic test_reset_track();
        bus_if.settle_len = 8'd0; bus_if.acq_len = 16'd0;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        step(); step();
        tick_step();
        checks++; if (bus_if.locked !== 1'b1) begin failures++; $display("FAIL rt_locked: got %b exp 1", bus_if.locked); end
        digrf_rst = 1'b1; bus_if.start = 1'b1; bus_if.dlf_tick = 1'b1; bus_if.lock_ind = 1'b0;
        step();
        checks++; if (bus_if.state !== 3'd0 || bus_if.dlf_en !== 1'b0 || bus_if.coef_upd !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.locked !== 1'b0) begin failures++; $display("FAIL rt_ctrl: got st=%0d en=%b upd=%b busy=%b lk=%b exp all 0", bus_if.state, bus_if.dlf_en, bus_if.coef_upd, bus_if.busy, bus_if.locked); end
        checks++; if (coef_obs !== 64'd0 || bus_if.relock_cnt !== 8'd0) begin failures++; $display("FAIL rt_coef_cnt: got %h cnt=%0d exp 0 0", coef_obs, bus_if.relock_cnt); end
        digrf_rst = 1'b0; bus_if.start = 1'b0; bus_if.dlf_tick = 1'b0; bus_if.lock_ind = 1'b1;
        step();
        test_preload();
    endtask

    initial begin
        checks = 0; failures = 0;
        c_acq_a2 = -16'sd31934; c_acq_a3 = 16'sd15552; c_acq_b1 = 16'sd1594; c_acq_b2 = -16'sd1587;
        c_trk_a2 = 16'sd12000;  c_trk_a3 = -16'sd5000; c_trk_b1 = -16'sd777; c_trk_b2 = 16'sd2222;
        acq_vec = {c_acq_a2, c_acq_a3, c_acq_b1, c_acq_b2};
        trk_vec = {c_trk_a2, c_trk_a3, c_trk_b1, c_trk_b2};
        digrf_rst = 1'b1;
        bus_if.start = 1'b0; bus_if.stop = 1'b0; bus_if.dlf_tick = 1'b0; bus_if.lock_ind = 1'b1;
        bus_if.acq_a2 = '0; bus_if.acq_a3 = '0; bus_if.acq_b1 = '0; bus_if.acq_b2 = '0;
        bus_if.trk_a2 = '0; bus_if.trk_a3 = '0; bus_if.trk_b1 = '0; bus_if.trk_b2 = '0;
        bus_if.acq_len = '0; bus_if.settle_len = '0;

        test_reset();
        test_preload();
        test_acq_track();
        test_relock();
        test_zero_len();
        test_stop();
        test_reset_track();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
